// File: rtl/cook_timer.sv
// cook_timer: kitchen countdown timer, MM:SS in BCD, counting down once per
// 1 Hz tick while running, with a buzzer pulse when the countdown completes.
//
// Ports
//   clk_100Hz            system clock (100 Hz), all state changes on rising edge
//   rst_n                asynchronous active-low reset
//   hz1                  1 Hz square wave; each rising edge is one countdown tick
//   load                 load the clamped preset digits (ignored while running)
//   set_mt/mu/st/su      BCD preset: minute tens/units, second tens/units
//   start                begin or resume countdown
//   pause                freeze countdown
//   clear                abort and zero the timer (highest priority)
//   mt/mu/st/su          remaining time, BCD MM:SS
//   state                00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//   running              high only in RUN (magnetron enable)
//   beep                 buzzer enable, high for BEEP_TICKS ticks after completion
module cook_timer #(
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic       hz1,
  input  logic       load,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mu,
  input  logic [3:0] set_st,
  input  logic [3:0] set_su,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic [1:0] state,
  output logic       running,
  output logic       beep
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] time_r, time_nxt_s;      // {mt, mu, st, su}
  logic [15:0] time_dec_s;
  logic [3:0]  beep_cnt_r, beep_cnt_nxt_s;
  logic        beep_r, beep_nxt_s;
  logic        running_r;
  logic        hz1_q_r;
  logic        armed_r;                 // hz1 has been seen low since reset
  logic        tick_s;

  // Saturate a BCD digit at a given maximum value.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    logic [3:0] r;
    if (d > max_d) begin
      r = max_d;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // One-second BCD decrement of MM:SS with borrow chain; 00:00 stays 00:00.
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] a, b, c, d;
    {a, b, c, d} = t;
    if (t == 16'd0) begin
      a = 4'd0;
    end else if (d != 4'd0) begin
      d = d - 4'd1;
    end else begin
      d = 4'd9;
      if (c != 4'd0) begin
        c = c - 4'd1;
      end else begin
        c = 4'd5;
        if (b != 4'd0) begin
          b = b - 4'd1;
        end else begin
          b = 4'd9;
          a = a - 4'd1;
        end
      end
    end
    return {a, b, c, d};
  endfunction

  // A tick needs a real low-to-high transition seen after reset: if hz1 is
  // already high at reset release, armed_r keeps the first sample from
  // looking like an edge.
  assign tick_s     = hz1 & ~hz1_q_r & armed_r;
  assign time_dec_s = dec_time(time_r);

  // Next-state, digit and buzzer logic with clear > load > pause > start priority.
  always_comb begin
    state_nxt_s    = state_r;
    time_nxt_s     = time_r;
    beep_nxt_s     = beep_r;
    beep_cnt_nxt_s = beep_cnt_r;
    if (clear) begin
      state_nxt_s    = IDLE;
      time_nxt_s     = 16'd0;
      beep_nxt_s     = 1'b0;
      beep_cnt_nxt_s = 4'd0;
    end else if (load && (state_r != RUN)) begin
      state_nxt_s    = IDLE;
      time_nxt_s     = {clamp_digit(set_mt, 4'd9), clamp_digit(set_mu, 4'd9),
                        clamp_digit(set_st, 4'd5), clamp_digit(set_su, 4'd9)};
      beep_nxt_s     = 1'b0;
      beep_cnt_nxt_s = 4'd0;
    end else begin
      case (state_r)
        IDLE, PAUSED: begin
          if (start && (time_r != 16'd0)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        RUN: begin
          // pause wins over a coincident tick, which is simply dropped
          if (pause) begin
            state_nxt_s = PAUSED;
          end else if (tick_s) begin
            time_nxt_s = time_dec_s;
            if (time_dec_s == 16'd0) begin
              state_nxt_s    = DONE;
              beep_nxt_s     = 1'b1;
              beep_cnt_nxt_s = 4'(BEEP_TICKS);
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE: begin
          // beep drops on the tick that exhausts the counter
          if (tick_s && (beep_cnt_r != 4'd0)) begin
            beep_cnt_nxt_s = beep_cnt_r - 4'd1;
            beep_nxt_s     = (beep_cnt_r != 4'd1);
          end else begin
            beep_cnt_nxt_s = beep_cnt_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, digit, buzzer and tick-edge registers.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      time_r     <= 16'd0;
      beep_r     <= 1'b0;
      beep_cnt_r <= 4'd0;
      running_r  <= 1'b0;
      hz1_q_r    <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      time_r     <= time_nxt_s;
      beep_r     <= beep_nxt_s;
      beep_cnt_r <= beep_cnt_nxt_s;
      running_r  <= (state_nxt_s == RUN);
      hz1_q_r    <= hz1;
      armed_r    <= armed_r | ~hz1;
    end
  end

  assign mt      = time_r[15:12];
  assign mu      = time_r[11:8];
  assign st      = time_r[7:4];
  assign su      = time_r[3:0];
  assign state   = state_r;
  assign running = running_r;
  assign beep    = beep_r;

endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 Parameter BEEP_TICKS, default 3: number of 1 Hz ticks for which beep stays asserted after countdown ends; legal range 1..15.
REQ-002 clk_100Hz  input  1  system clock, 100 Hz; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 hz1  input  1  1 Hz square wave from the frequency divider; asynchronous to nothing, sampled on clk_100Hz.
REQ-005 load  input  1  level; loads preset digits.
REQ-006 set_mt, set_mu, set_st, set_su  input  4 each  BCD preset: minute tens, minute units, second tens, second units.
REQ-007 start  input  1  level; begin or resume countdown.
REQ-008 pause  input  1  level; freeze countdown.
REQ-009 clear  input  1  level; abort and zero the timer.
REQ-010 mt, mu, st, su  output  4 each  current remaining time, BCD MM:SS.
REQ-011 state  output  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE.
REQ-012 running  output  1  high only in RUN (magnetron enable).
REQ-013 beep  output  1  buzzer enable.

Function
REQ-014 Tick detection: hz1 registered into hz1_q each cycle; tick = hz1 AND NOT hz1_q; exactly one tick per hz1 rising edge.
REQ-015 Control priority within a cycle: clear > load > pause > start.
REQ-016 clear (any state): digits -> 0, state -> IDLE, beep -> 0, beep counter -> 0, next cycle.
REQ-017 load (IDLE, PAUSED or DONE): digits <- clamped preset, state -> IDLE, beep -> 0; load ignored in RUN.
REQ-018 Clamping: set_mt, set_mu, set_su >9 -> 9; set_st >5 -> 5; maximum time 99:59.
REQ-019 start in IDLE or PAUSED with digits non-zero: state -> RUN next cycle; with digits 00:00 stays IDLE.
REQ-020 pause in RUN: state -> PAUSED next cycle; digits hold; a tick in the same cycle as pause is discarded.
REQ-021 Decrement: in RUN, on a tick cycle, time decreases by exactly one second at that clock edge; no decrement in any other state.
REQ-022 Borrow chain: su 0 -> 9 borrow; st 0 -> 5 borrow; mu 0 -> 9 borrow; mt decrements; e.g. 10:00 -> 09:59, 01:00 -> 00:59.
REQ-023 Completion: decrement landing on 00:00 moves state to DONE on the same edge; running falls on the same edge; no wrap below 00:00.
REQ-024 Tick phase not reset by start; first decrement occurs at the next hz1 rising edge after entering RUN.
REQ-025 DONE: beep = 1 from DONE entry for BEEP_TICKS ticks, then 0; state remains DONE until clear or load.
REQ-026 start and pause ignored in DONE; start ignored in RUN; pause ignored outside RUN.
REQ-027 Outputs registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst_n low, asynchronously: digits 0, state IDLE, running 0, beep 0, hz1_q 0, beep counter 0.
REQ-029 Release of rst_n mid-countdown resumes nothing; block restarts in IDLE at 00:00.
REQ-030 If hz1 is high at reset release, no tick is generated until hz1 falls and rises again; hz1_q takes hz1 on the first clock after release.

Verification
REQ-031 Load 00:03, start, three hz1 rises -> 00:02, 00:01, 00:00; state 11 on third tick edge; running falls same edge.
REQ-032 Load 10:00, start, one tick -> 09:59; load 01:00, start, one tick -> 00:59.
REQ-033 Load 0A:7C (invalid BCD) -> reads 09:59; load 00:00 then start -> state stays 00.
REQ-034 Running 00:05, pause asserted with a tick in the same cycle -> holds 00:05, state 10; start -> resumes, next tick 00:04.
REQ-035 DONE with BEEP_TICKS=3 -> beep high for exactly 3 ticks then low; state stays 11; clear -> 00:00, state 00.
REQ-036 rst_n pulsed low between clock edges during RUN at 02:30 -> outputs zero immediately; after release, ticks cause no change.
